// File: rtl/cory_queue_ctl.sv
`default_nettype none
// ============================================================================
// Module  : cory_queue_ctl
// Brief   : Valid/ready FIFO queue with occupancy count, almost-full/empty
//           flags, synchronous flush and optional empty-queue fall-through.
// Revision: 1.0 - initial release
// ============================================================================
module cory_queue_ctl #(
    parameter int N      = 8,
    parameter int Q      = 4,
    parameter int AF     = Q - 1,
    parameter int AE     = 1,
    parameter int BYPASS = 0,
    localparam int C     = $clog2(Q + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a_v,
    input  logic [N-1:0] i_a_d,
    output logic         o_a_r,
    output logic         o_z_v,
    output logic [N-1:0] o_z_d,
    input  logic         i_z_r,
    input  logic         i_flush,
    output logic [C-1:0] o_z_cnt,
    output logic         o_a_afull,
    output logic         o_z_aempty
);

    localparam int           c_PTR_W = $clog2(Q);
    localparam logic [C-1:0] c_Q     = C'(Q);
    localparam logic [C-1:0] c_AF    = C'(AF);
    localparam logic [C-1:0] c_AE    = C'(AE);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(Q - 1);
    localparam bit           c_BYP   = (BYPASS != 0);

    logic [N-1:0]       r_mem [Q];
    logic [C-1:0]       r_cnt;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_thru;
    logic w_wr;
    logic w_rd;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == c_Q);

    // Ready looks only at stored occupancy, so a full queue refuses a push
    // even in a cycle where it is also being drained.
    assign o_a_r = !w_full && !i_flush;
    assign o_z_v = (!w_empty || (c_BYP && i_a_v)) && !i_flush;
    assign o_z_d = (c_BYP && w_empty) ? i_a_d : r_mem[r_rptr];

    assign w_push = i_a_v && o_a_r;
    assign w_pop  = o_z_v && i_z_r;

    // A word handed straight through an empty queue never touches storage.
    assign w_thru = c_BYP && w_empty && w_push && w_pop;
    assign w_wr   = w_push && !w_thru;
    assign w_rd   = w_pop && !w_thru;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + c_PTR_W'(1);
            end
            if (w_rd) begin
                r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + c_PTR_W'(1);
            end
            if (w_wr && !w_rd) begin
                r_cnt <= r_cnt + C'(1);
            end else if (w_rd && !w_wr) begin
                r_cnt <= r_cnt - C'(1);
            end
        end
    end

    // Storage has no reset: flush and reset only move the pointers.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_a_d;
        end
    end

    assign o_z_cnt    = r_cnt;
    assign o_a_afull  = (r_cnt >= c_AF);
    assign o_z_aempty = (r_cnt <= c_AE);

endmodule
`default_nettype wire

// File: tb/tb_cory_queue_ctl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cory_queue_ctl
// Brief   : Drives a Q=4 plain queue and a Q=3 fall-through queue with the
//           same stimulus and compares both against queue-based models.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cory_queue_ctl;

    logic       clk;
    logic       reset_n;
    logic       a_v;
    logic [7:0] a_d;
    logic       z_r;
    logic       flush;

    logic       ar0, zv0, af0, ae0;
    logic [7:0] zd0;
    logic [2:0] cnt0;
    logic       ar1, zv1, af1, ae1;
    logic [7:0] zd1;
    logic [1:0] cnt1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m0[$];
    logic [7:0] m1[$];

    cory_queue_ctl #(.N(8), .Q(4), .BYPASS(0)) u_q4 (
        .clk(clk), .reset_n(reset_n), .i_a_v(a_v), .i_a_d(a_d), .o_a_r(ar0),
        .o_z_v(zv0), .o_z_d(zd0), .i_z_r(z_r), .i_flush(flush),
        .o_z_cnt(cnt0), .o_a_afull(af0), .o_z_aempty(ae0)
    );

    cory_queue_ctl #(.N(8), .Q(3), .BYPASS(1)) u_q3 (
        .clk(clk), .reset_n(reset_n), .i_a_v(a_v), .i_a_d(a_d), .o_a_r(ar1),
        .o_z_v(zv1), .o_z_d(zd1), .i_z_r(z_r), .i_flush(flush),
        .o_z_cnt(cnt1), .o_a_afull(af1), .o_z_aempty(ae1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, check outputs against the models, advance models.
    task automatic cycle(input logic av, input logic [7:0] ad, input logic zr, input logic fl);
        int  s0, s1;
        bit  e_ar0, e_zv0, e_ar1, e_zv1, push, pop;
        @(negedge clk);
        a_v = av; a_d = ad; z_r = zr; flush = fl;
        #1;
        s0 = m0.size();
        s1 = m1.size();
        e_ar0 = (s0 < 4) && !fl;
        e_zv0 = (s0 > 0) && !fl;
        e_ar1 = (s1 < 3) && !fl;
        e_zv1 = ((s1 > 0) || av) && !fl;
        chk("q4_a_r",   32'(ar0), 32'(e_ar0));
        chk("q4_z_v",   32'(zv0), 32'(e_zv0));
        chk("q4_cnt",   32'(cnt0), 32'(s0));
        chk("q4_afull", 32'(af0), 32'(s0 >= 3));
        chk("q4_aempty",32'(ae0), 32'(s0 <= 1));
        if (e_zv0) chk("q4_z_d", 32'(zd0), 32'(m0[0]));
        chk("q3_a_r",   32'(ar1), 32'(e_ar1));
        chk("q3_z_v",   32'(zv1), 32'(e_zv1));
        chk("q3_cnt",   32'(cnt1), 32'(s1));
        chk("q3_afull", 32'(af1), 32'(s1 >= 2));
        chk("q3_aempty",32'(ae1), 32'(s1 <= 1));
        if (e_zv1) chk("q3_z_d", 32'(zd1), 32'((s1 > 0) ? m1[0] : ad));
        @(posedge clk);
        if (fl) begin
            m0.delete();
            m1.delete();
        end else begin
            push = av && e_ar0;
            pop  = e_zv0 && zr;
            if (pop) void'(m0.pop_front());
            if (push) m0.push_back(ad);
            push = av && e_ar1;
            pop  = e_zv1 && zr;
            if (pop && s1 > 0) void'(m1.pop_front());
            if (push && !(pop && s1 == 0)) m1.push_back(ad);
        end
    endtask

    initial begin
        reset_n = 1'b0; a_v = 1'b0; a_d = '0; z_r = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_q4_a_r",    32'(ar0),  32'd1);
        chk("rst_q4_z_v",    32'(zv0),  32'd0);
        chk("rst_q4_cnt",    32'(cnt0), 32'd0);
        chk("rst_q4_afull",  32'(af0),  32'd0);
        chk("rst_q4_aempty", 32'(ae0),  32'd1);
        chk("rst_q3_z_v",    32'(zv1),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill with the consumer stalled, then drain in order.
        cycle(1, 8'h11, 0, 0);
        cycle(1, 8'h22, 0, 0);
        cycle(1, 8'h33, 0, 0);
        cycle(1, 8'h44, 0, 0);
        // Full queue with push and pop requested together.
        cycle(1, 8'h55, 1, 0);
        cycle(1, 8'h66, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 0);

        // Empty fall-through on the Q=3 instance.
        cycle(1, 8'h5A, 1, 0);
        cycle(0, 8'h00, 1, 0);

        // Flush at occupancy 3 with push and pop requested.
        cycle(1, 8'hA1, 0, 0);
        cycle(1, 8'hA2, 0, 0);
        cycle(1, 8'hA3, 0, 0);
        cycle(1, 8'hA4, 1, 1);
        cycle(0, 8'h00, 1, 0);

        // Streaming: prime two words, then push and pop every cycle.
        cycle(1, 8'h01, 0, 0);
        cycle(1, 8'h02, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 8'(8'h10 + i), 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end

        // Asynchronous reset between edges at occupancy 2.
        cycle(0, 8'h00, 1, 1);
        cycle(1, 8'hB1, 0, 0);
        cycle(1, 8'hB2, 0, 0);
        @(negedge clk);
        a_v = 1'b0; z_r = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_q4_cnt", 32'(cnt0), 32'd0);
        chk("arst_q4_z_v", 32'(zv0),  32'd0);
        chk("arst_q3_cnt", 32'(cnt1), 32'd0);
        chk("arst_q3_z_v", 32'(zv1),  32'd0);
        m0.delete();
        m1.delete();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1, 8'hC1, 0, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cory_queue_ctl.md
CORY_QUEUE_CTL -- requirements
Module: cory_queue_ctl

Interface
REQ-001 SHALL provide parameter N, default 8: data width in bits, N>=1.
REQ-002 SHALL provide parameter Q, default 4: queue depth in entries, Q>=2; non-power-of-two values are legal.
REQ-003 SHALL provide parameter AF, default Q-1: almost-full threshold, 1<=AF<=Q.
REQ-004 SHALL provide parameter AE, default 1: almost-empty threshold, 0<=AE<Q.
REQ-005 SHALL provide parameter BYPASS, default 0: 1 enables same-cycle fall-through when the queue is empty.
REQ-006 SHALL define C = clog2(Q+1) as the width of the occupancy count.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 i_a_v  input  1  upstream valid.
REQ-010 i_a_d  input  N  upstream data.
REQ-011 o_a_r  output  1  upstream ready.
REQ-012 o_z_v  output  1  downstream valid.
REQ-013 o_z_d  output  N  downstream data.
REQ-014 i_z_r  input  1  downstream ready.
REQ-015 i_flush  input  1  synchronous flush request.
REQ-016 o_z_cnt  output  C  current occupancy (stored entries only).
REQ-017 o_a_afull  output  1  almost full.
REQ-018 o_z_aempty  output  1  almost empty.

Function
REQ-019 A push SHALL occur in a cycle with i_a_v && o_a_r; a pop SHALL occur in a cycle with o_z_v && i_z_r.
REQ-020 o_a_r SHALL be (cnt<Q) && !i_flush; o_a_r SHALL have no combinational dependence on i_z_r, so a full queue refuses a push even while popping.
REQ-021 o_z_v SHALL be (cnt>0) && !i_flush when BYPASS=0.
REQ-022 o_z_v SHALL be ((cnt>0) || i_a_v) && !i_flush when BYPASS=1.
REQ-023 When cnt>0, o_z_d SHALL equal the oldest stored entry (FIFO order).
REQ-024 When BYPASS=1 and cnt==0, o_z_d SHALL equal i_a_d.
REQ-025 When o_z_v=0, o_z_d SHALL be don't-care.
REQ-026 Under BYPASS=1 with cnt==0, a push that is consumed in the same cycle (i_z_r=1) SHALL NOT be written to storage, and cnt SHALL stay 0.
REQ-027 Storage SHALL be a Q-entry array addressed by a write pointer and a read pointer, each wrapping from Q-1 to 0.
REQ-028 cnt SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop, unchanged when neither occurs.
REQ-029 Latency SHALL be: BYPASS=0, a pushed word is visible on o_z_v/o_z_d one cycle after the push; BYPASS=1 with cnt==0, zero cycles.
REQ-030 Full throughput SHALL be one word per cycle at any occupancy 0<cnt<Q.
REQ-031 o_z_cnt SHALL equal cnt, driven from a register.
REQ-032 o_a_afull SHALL be (cnt>=AF), and o_z_aempty SHALL be (cnt<=AE), both decoded from the registered cnt.
REQ-033 Flush: while i_flush=1, no push or pop SHALL occur; on that edge, cnt, the read pointer and the write pointer SHALL all clear to 0.
REQ-034 Flush SHALL take priority over simultaneous i_a_v and i_z_r.
REQ-035 Storage contents SHALL be left unchanged by flush and reset.
REQ-036 Overflow and underflow SHALL be impossible by construction: no write when cnt==Q, no read when cnt==0 except the bypass path.

Reset
REQ-037 While reset_n=0, state SHALL be cnt=0, both pointers=0; outputs SHALL be o_a_r=1, o_z_v=0 (BYPASS=0), o_z_cnt=0, o_a_afull=0, o_z_aempty=1.
REQ-038 Reset asserted mid-operation SHALL discard all queued entries immediately, without waiting for a clock edge.
REQ-039 The first push SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-040 Q=4, BYPASS=0: push 0x11,0x22,0x33,0x44 with i_z_r=0 -> o_z_cnt=4, o_a_r=0, o_a_afull=1; then i_z_r=1 -> outputs 0x11..0x44 in order, final cnt=0, o_z_aempty=1.
REQ-041 Q=3, streaming: continuous push and pop for 10 words -> one word per cycle, cnt constant, pointers wrap 2->0, data order preserved.
REQ-042 Q=4, full queue with i_a_v=1, i_z_r=1 -> pop occurs, push refused that cycle, cnt=3, o_a_r=1 on the next cycle.
REQ-043 BYPASS=1, empty queue, i_a_v=1, i_a_d=0x5A, i_z_r=1 -> o_z_v=1 and o_z_d=0x5A in the same cycle, cnt stays 0.
REQ-044 cnt=3, i_flush=1 with i_a_v=1 and i_z_r=1 -> o_a_r=0, o_z_v=0, next cycle cnt=0 and o_z_v=0.
REQ-045 cnt=2, reset_n pulsed low between clock edges -> o_z_cnt=0 and o_z_v=0 immediately, before the next clock edge.
